// File: rtl/ai_traffic_cars_pkg.sv
// Shared types and constants for the AI traffic car pool: slot record, mask colour, sprite texels.
package ai_traffic_pkg;
  localparam logic [7:0] MASK_VALUE         = 8'h62;
  localparam int         CAR_SIZE           = 64;
  localparam int         SPRITE_SCALE_SHIFT = 2;

  typedef struct packed {
    logic               active;
    logic [2:0]         lane;
    logic [10:0]        x;
    logic signed [11:0] y;
  } car_t;

  // 16x16 top-down car, indexed [row][col]; 8'h62 texels are transparent
  localparam logic [7:0] SPRITE [16][16] = '{
    '{8'h62,8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62,8'h62},
    '{8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62},
    '{8'h00,8'he4,8'he4,8'he4,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'he4,8'he4,8'he4,8'h00},
    '{8'h00,8'he4,8'he4,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'he4,8'he4,8'h00},
    '{8'h00,8'he4,8'he4,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'he4,8'he4,8'h00},
    '{8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62},
    '{8'h62,8'he4,8'he4,8'hff,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'hff,8'he4,8'he4,8'h62},
    '{8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62},
    '{8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62},
    '{8'h62,8'he4,8'he4,8'hff,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'hff,8'he4,8'he4,8'h62},
    '{8'h62,8'he4,8'he4,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'he4,8'he4,8'h62},
    '{8'h00,8'he4,8'he4,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'h92,8'he4,8'he4,8'h00},
    '{8'h00,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h00},
    '{8'h00,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h00},
    '{8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62},
    '{8'h62,8'h62,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'he4,8'h62,8'h62}
  };

  function automatic logic [10:0] lane_x(input logic [2:0] lane, input int x0, input int pitch);
    return 11'(x0 + int'(lane) * pitch);
  endfunction
endpackage

// File: rtl/ai_traffic_cars_if.sv
// Pixel request/response bundle between the scan-out requester and the traffic car drawer.
interface ai_traffic_cars_if #(parameter int NUM_CARS = 4);
  localparam int IW = $clog2(NUM_CARS);
  logic [10:0]   requested_x;
  logic [10:0]   requested_y;
  logic [7:0]    output_color;
  logic          draw_request;
  logic [IW-1:0] hit_car;

  modport master (output requested_x, requested_y, input output_color, draw_request, hit_car);
  modport slave  (input requested_x, requested_y, output output_color, draw_request, hit_car);
endinterface

// File: rtl/ai_traffic_cars_sprite_rom.sv
// Registered 16x16x8 car sprite ROM; one texel read per clock.
module traffic_sprite_rom
  import ai_traffic_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [7:0] color_o
);
  logic [7:0] color_q;

  always_ff @(posedge clk) color_q <= SPRITE[row_i][col_i];

  assign color_o = color_q;
endmodule

// File: rtl/ai_traffic_cars.sv
// Opponent car pool: spawn/scroll/retire per frame plus 2-stage pixel lookup.
// Define AI_TRAFFIC_SWAY_EN to make odd-index cars drift +/-8 px around their lane.
module ai_traffic_cars
  import ai_traffic_pkg::*;
#(
  parameter int NUM_CARS     = 4,
  parameter int NUM_LANES    = 4,
  parameter int LANE_X0      = 180,
  parameter int LANE_PITCH   = 60,
  parameter int SPAWN_FRAMES = 48,
  parameter int SPAWN_GAP    = 80,
  parameter int SPEED_SHIFT  = 5,
  parameter int SCREEN_H     = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                clear_cars,
  input  logic [9:0]          player_speed,
  input  logic [10:0]         random,
  output logic [NUM_CARS-1:0] active_mask,
  ai_traffic_cars_if.slave    pix
);
  localparam int IW = $clog2(NUM_CARS);
  localparam int TW = $clog2(SPAWN_FRAMES + 1);
  localparam logic [TW-1:0]      TIMER_RELOAD = TW'(SPAWN_FRAMES - 1);
  localparam logic signed [11:0] GAP_Y        = 12'(SPAWN_GAP - CAR_SIZE);
  localparam logic signed [11:0] DESPAWN_Y    = 12'(SCREEN_H);
  localparam logic signed [11:0] SPAWN_Y      = 12'(-CAR_SIZE);
  localparam logic signed [12:0] SIZE13       = 13'(CAR_SIZE);

  car_t [NUM_CARS-1:0] cars_q, cars_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [7:0]          lane_blocked;
  logic                free_found, lane_found;
  logic [IW-1:0]       free_idx;
  logic [2:0]          base_lane, spawn_lane;
  logic [3:0]          lane_sum;
  logic [11:0]         step;
`ifdef AI_TRAFFIC_SWAY_EN
  logic [NUM_CARS-1:0] dir_q, dir_d;
  logic [10:0]         lx;
`endif

  assign step = 12'(player_speed >> SPEED_SHIFT);

  always_comb begin
    lane_blocked = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (cars_q[i].active && cars_q[i].y < GAP_Y) lane_blocked[cars_q[i].lane] = 1'b1;
      if (!cars_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    // Walk lanes from the random pick with wrap; descending loop lets the first clear lane win
    base_lane  = 3'(random % 11'(NUM_LANES));
    lane_found = 1'b0;
    spawn_lane = '0;
    lane_sum   = '0;
    for (int t = NUM_LANES - 1; t >= 0; t--) begin
      lane_sum = 4'(base_lane) + 4'(t);
      if (lane_sum >= 4'(NUM_LANES)) lane_sum = lane_sum - 4'(NUM_LANES);
      if (!lane_blocked[lane_sum[2:0]]) begin
        lane_found = 1'b1;
        spawn_lane = lane_sum[2:0];
      end
    end
  end

  always_comb begin
    cars_d  = cars_q;
    timer_d = timer_q;
`ifdef AI_TRAFFIC_SWAY_EN
    dir_d = dir_q;
    lx    = '0;
`endif
    if (clear_cars) begin
      for (int i = 0; i < NUM_CARS; i++) cars_d[i].active = 1'b0;
      timer_d = TIMER_RELOAD;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        if (cars_q[i].active) begin
          if (cars_q[i].y >= DESPAWN_Y) cars_d[i].active = 1'b0;
          else begin
            cars_d[i].y = cars_q[i].y + $signed(step);
`ifdef AI_TRAFFIC_SWAY_EN
            if (i % 2 == 1) begin
              lx = lane_x(cars_q[i].lane, LANE_X0, LANE_PITCH);
              if (dir_q[i] && cars_q[i].x >= lx + 11'd8) dir_d[i] = 1'b0;
              else if (!dir_q[i] && cars_q[i].x <= lx - 11'd8) dir_d[i] = 1'b1;
              cars_d[i].x = dir_d[i] ? cars_q[i].x + 11'd1 : cars_q[i].x - 11'd1;
            end
`endif
          end
        end
      end
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      else if (free_found && lane_found) begin
        cars_d[free_idx] = '{active: 1'b1, lane: spawn_lane,
                             x: lane_x(spawn_lane, LANE_X0, LANE_PITCH), y: SPAWN_Y};
        timer_d = TIMER_RELOAD;
`ifdef AI_TRAFFIC_SWAY_EN
        dir_d[free_idx] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cars_q  <= '0;
      timer_q <= TIMER_RELOAD;
    end else begin
      cars_q  <= cars_d;
      timer_q <= timer_d;
    end
  end

`ifdef AI_TRAFFIC_SWAY_EN
  always_ff @(posedge clk) begin
    if (reset) dir_q <= '1;
    else       dir_q <= dir_d;
  end
`endif

  always_comb
    for (int i = 0; i < NUM_CARS; i++) active_mask[i] = cars_q[i].active;

  logic [NUM_CARS-1:0] pix_hit;
  logic signed [12:0]  ry_s, car_y;
  logic [IW-1:0]       s1_idx_d, s1_idx_q, s2_idx_q;
  logic [3:0]          s1_row_d, s1_row_q, s1_col_d, s1_col_q;
  logic [1:0]          vld_pipe_q;
  logic [7:0]          rom_color;
  logic                draw;

  always_comb begin
    ry_s     = $signed({2'b00, pix.requested_y});
    car_y    = '0;
    pix_hit  = '0;
    s1_idx_d = '0;
    s1_row_d = '0;
    s1_col_d = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      car_y = 13'(cars_q[i].y);
      pix_hit[i] = cars_q[i].active
        && {1'b0, pix.requested_x} >= {1'b0, cars_q[i].x}
        && {1'b0, pix.requested_x} <  {1'b0, cars_q[i].x} + 12'(CAR_SIZE)
        && ry_s >= car_y && ry_s < car_y + SIZE13;
      if (pix_hit[i]) begin
        s1_idx_d = IW'(i);
        s1_row_d = 4'((ry_s - car_y) >> SPRITE_SCALE_SHIFT);
        s1_col_d = 4'((pix.requested_x - cars_q[i].x) >> SPRITE_SCALE_SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_idx_q   <= '0;
      s2_idx_q   <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], |pix_hit};
      s1_idx_q   <= s1_idx_d;
      s2_idx_q   <= s1_idx_q;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
    end
  end

  traffic_sprite_rom u_rom (
    .clk    (clk),
    .row_i  (s1_row_q),
    .col_i  (s1_col_q),
    .color_o(rom_color)
  );

  assign draw             = vld_pipe_q[1] && (rom_color != MASK_VALUE);
  assign pix.draw_request = draw;
  assign pix.output_color = draw ? rom_color : MASK_VALUE;
  assign pix.hit_car      = s2_idx_q;
endmodule

// File: tb/tb_ai_traffic_cars.sv
// Directed bench for ai_traffic_cars: spawn, lane skip, scroll/retire, pixel path, clear.
module tb_ai_traffic_cars;
  logic        clk = 1'b0;
  logic        reset, frame_start, clear_cars;
  logic [9:0]  player_speed;
  logic [10:0] random;
  logic [3:0]  active_mask;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ai_traffic_cars_if #(.NUM_CARS(4)) pix ();

  ai_traffic_cars dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .clear_cars  (clear_cars),
    .player_speed(player_speed),
    .random      (random),
    .active_mask (active_mask),
    .pix         (pix)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic req(input int x, input int y);
    pix.requested_x = 11'(x);
    pix.requested_y = 11'(y);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; clear_cars = 1'b0;
    player_speed = '0; random = '0;
    req(0, 0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_color", pix.output_color, 8'h62);
    chk("rst_draw",  pix.draw_request, 0);
    chk("rst_hit",   pix.hit_car, 0);
    chk("rst_mask",  active_mask, 0);
    chk("rst_timer", dut.timer_q, 47);

    // First spawn lands on the 48th frame
    random = 11'd6;
    frames(47);
    chk("pre_spawn_mask", active_mask, 0);
    frames(1);
    chk("spawn_mask", active_mask, 4'b0001);
    chk("spawn_lane", dut.cars_q[0].lane, 2);
    chk("spawn_x",    dut.cars_q[0].x, 300);
    chk("spawn_y",    dut.cars_q[0].y, -64);

    clear_cars = 1'b1; tick(); clear_cars = 1'b0;
    chk("clear_mask",  active_mask, 0);
    chk("clear_timer", dut.timer_q, 47);

    // Lane 1 car parked at y=-20 forces the next spawn into lane 2
    random = 11'd1;
    frames(48);
    chk("l1_mask", active_mask, 4'b0001);
    chk("l1_x",    dut.cars_q[0].x, 240);
    frames(45);
    player_speed = 10'd704;
    frames(2);
    chk("l1_y",    dut.cars_q[0].y, -20);
    chk("l1_timer", dut.timer_q, 0);
    player_speed = '0;
    frames(1);
    chk("skip_mask", active_mask, 4'b0011);
    chk("skip_lane", dut.cars_q[1].lane, 2);
    chk("skip_x",    dut.cars_q[1].x, 300);
    chk("skip_y",    dut.cars_q[1].y, -64);
    chk("held_y0",   dut.cars_q[0].y, -20);

    // Scroll: slot1 to (300,100), slot0 to (240,144)
    player_speed = 10'd992; frames(4);
    player_speed = 10'd640; frames(2);
    player_speed = '0;
    chk("mv_y1", dut.cars_q[1].y, 100);
    chk("mv_y0", dut.cars_q[0].y, 144);

    req(305, 106); tick();
    req(300, 100); tick();
    chk("px_color", pix.output_color, 8'he4);
    chk("px_draw",  pix.draw_request, 1);
    chk("px_hit",   pix.hit_car, 1);
    req(301, 155); tick();
    chk("px_corner_color", pix.output_color, 8'h62);
    chk("px_corner_draw",  pix.draw_request, 0);
    req(100, 100); tick();
    chk("px_overlap_color", pix.output_color, 8'h00);
    chk("px_overlap_draw",  pix.draw_request, 1);
    chk("px_overlap_hit",   pix.hit_car, 0);
    tick();
    chk("px_miss_color", pix.output_color, 8'h62);
    chk("px_miss_draw",  pix.draw_request, 0);

    // Retire: slot0 leaves first, slot1 rides to 470, 480, then out
    player_speed = 10'd992; frames(11);
    player_speed = 10'd928; frames(1);
    chk("ret0_mask", active_mask, 4'b0010);
    chk("ret_y470",  dut.cars_q[1].y, 470);
    player_speed = 10'd320; frames(1);
    chk("ret_y480",  dut.cars_q[1].y, 480);
    chk("ret_480_mask", active_mask, 4'b0010);
    frames(1);
    chk("ret1_mask", active_mask, 4'b0000);

    // Fill all four slots across lanes 0..3
    player_speed = '0; random = '0;
    frames(27);
    chk("fill_pre_mask", active_mask, 0);
    frames(1);
    chk("fill1_mask", active_mask, 4'b0001);
    frames(48);
    chk("fill2_mask", active_mask, 4'b0011);
    frames(48);
    chk("fill3_mask", active_mask, 4'b0111);
    frames(48);
    chk("fill4_mask", active_mask, 4'b1111);
    chk("fill4_lane", dut.cars_q[3].lane, 3);
    chk("fill4_x",    dut.cars_q[3].x, 360);
    frames(48);
    chk("full_mask",  active_mask, 4'b1111);
    chk("full_timer", dut.timer_q, 0);

    clear_cars = 1'b1; frame_start = 1'b1; tick();
    clear_cars = 1'b0; frame_start = 1'b0;
    chk("clrfrm_mask",  active_mask, 0);
    chk("clrfrm_timer", dut.timer_q, 47);
    frames(47);
    chk("clrfrm_quiet", active_mask, 0);
    frames(1);
    chk("clrfrm_spawn", active_mask, 4'b0001);
    chk("clrfrm_x",     dut.cars_q[0].x, 180);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
